// File: rtl/trap_controller.sv
// M-mode trap entry/return sequencer: owns mepc/mcause/mtval/MIE/MPIE, kills and redirects.
// Optional macro TRAP_VECTORED_EN: interrupts vector to base + 4*cause when mtvec_i[1:0]==2'b01.
module trap_controller #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter int          XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            illegal_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            mie_set_i,
  input  logic            mie_clr_i,
  input  logic            timer_irq_i,
  input  logic            ext_irq_i,
  output logic            kill_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
  output logic            mstatus_mie_o,
  output logic            mstatus_mpie_o
);
  typedef enum logic [1:0] {IDLE, TRAP, RET} state_e;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  state_e      state_q;
  logic [31:0] mepc_q, mcause_q, mtval_q;
  logic        mie_q, mpie_q;

  logic        trap_req, ret_req;
  logic [31:0] cause_d, tval_d;
  logic [31:0] base, target;

  // Interrupts are level-sensitive, so they simply wait here until a valid slot in IDLE.
  always_comb begin
    trap_req = 1'b0;
    ret_req  = 1'b0;
    cause_d  = 32'h0;
    tval_d   = 32'h0;
    if (state_q == IDLE && valid_i) begin
      if (ext_irq_i && mie_q) begin
        trap_req = 1'b1; cause_d = 32'h8000_000B;
      end else if (timer_irq_i && mie_q) begin
        trap_req = 1'b1; cause_d = 32'h8000_0007;
      end else if (illegal_i) begin
        trap_req = 1'b1; cause_d = 32'd2;  tval_d = instr_i;
      end else if (instr_i == EBREAK) begin
        trap_req = 1'b1; cause_d = 32'd3;  tval_d = pc_i;
      end else if (instr_i == ECALL) begin
        trap_req = 1'b1; cause_d = 32'd11;
      end else if (instr_i == MRET) begin
        ret_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trap_req) begin
            state_q  <= TRAP;
            mepc_q   <= pc_i;
            mcause_q <= cause_d;
            mtval_q  <= tval_d;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
          end else if (ret_req) begin
            state_q <= RET;
            mie_q   <= mpie_q;
            mpie_q  <= 1'b1;
          end else if (mie_clr_i) begin
            mie_q <= 1'b0;
          end else if (mie_set_i) begin
            mie_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // An all-zero mtvec is treated as not wired up and falls back to the reset base.
  assign base = (mtvec_i == 32'h0) ? {RESET_MTVEC[31:2], 2'b00} : {mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign target = (mtvec_i[1:0] == 2'b01 && mcause_q[31])
                ? base + {26'h0, mcause_q[3:0], 2'b00} : base;
`else
  assign target = base;
`endif

  assign kill_o         = trap_req | ret_req;
  assign stall_o        = (state_q != IDLE);
  assign redirect_o     = (state_q != IDLE);
  assign redirect_pc_o  = (state_q == TRAP) ? target :
                          (state_q == RET)  ? mepc_q : 32'h0;
  assign mepc_o         = mepc_q;
  assign mcause_o       = mcause_q;
  assign mtval_o        = mtval_q;
  assign mstatus_mie_o  = mie_q;
  assign mstatus_mpie_o = mpie_q;
endmodule

// File: tb/tb_trap_controller.sv
// Directed table-driven bench for trap_controller plus a mid-sequence reset scenario.
module tb_trap_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, illegal_i = 1'b0, mie_set_i = 1'b0, mie_clr_i = 1'b0;
  logic        timer_irq_i = 1'b0, ext_irq_i = 1'b0;
  logic [31:0] instr_i = '0, pc_i = '0, mtvec_i = 32'h800;
  logic        kill_o, stall_o, redirect_o, mstatus_mie_o, mstatus_mpie_o;
  logic [31:0] redirect_pc_o, mepc_o, mcause_o, mtval_o;

  trap_controller dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i),
    .illegal_i(illegal_i), .mtvec_i(mtvec_i), .mie_set_i(mie_set_i), .mie_clr_i(mie_clr_i),
    .timer_irq_i(timer_irq_i), .ext_irq_i(ext_irq_i), .kill_o(kill_o), .stall_o(stall_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .mepc_o(mepc_o),
    .mcause_o(mcause_o), .mtval_o(mtval_o), .mstatus_mie_o(mstatus_mie_o),
    .mstatus_mpie_o(mstatus_mpie_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [31:0] instr; logic [31:0] pc; logic ill; logic [31:0] mtvec;
    logic set; logic clr; logic tmr; logic ext;
    logic kill; logic stall; logic redir; logic [31:0] rpc;
    logic [31:0] mepc; logic [31:0] mcause; logic [31:0] mtval; logic mie; logic mpie;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] EXT_RPC = 32'h0000_082C;
`else
  localparam logic [31:0] EXT_RPC = 32'h0000_0800;
`endif

  task automatic add(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                     input logic ill, input logic [31:0] mtvec, input logic set,
                     input logic clr, input logic tmr, input logic ext,
                     input logic kill, input logic stall, input logic redir,
                     input logic [31:0] rpc, input logic [31:0] mepc,
                     input logic [31:0] mcause, input logic [31:0] mtval,
                     input logic mie, input logic mpie);
    vec_t t;
    t.v = v; t.instr = instr; t.pc = pc; t.ill = ill; t.mtvec = mtvec;
    t.set = set; t.clr = clr; t.tmr = tmr; t.ext = ext;
    t.kill = kill; t.stall = stall; t.redir = redir; t.rpc = rpc;
    t.mepc = mepc; t.mcause = mcause; t.mtval = mtval; t.mie = mie; t.mpie = mpie;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive_idle();
    valid_i = 0; instr_i = NOP; pc_i = '0; illegal_i = 0;
    mie_set_i = 0; mie_clr_i = 0; timer_irq_i = 0; ext_irq_i = 0;
  endtask

  initial begin
    //  v instr          pc     ill mtvec  set clr tmr ext | kill stl rdr rpc    mepc   mcause        mtval          mie mpie
    add(0, NOP,          0,     0, 32'h800, 0, 0, 0, 0,   0, 0, 0, 0,       0,     0,            0,             0, 0); // 0 reset
    add(0, NOP,          0,     0, 32'h800, 1, 0, 0, 0,   0, 0, 0, 0,       0,     0,            0,             0, 0); // 1
    add(0, NOP,          0,     0, 32'h800, 0, 0, 0, 0,   0, 0, 0, 0,       0,     0,            0,             1, 0); // 2
    add(1, 32'hFFFFFFFF, 32'h100, 1, 32'h800, 0, 0, 0, 0, 1, 0, 0, 0,       0,     0,            0,             1, 0); // 3 illegal
    add(0, NOP,          0,     0, 32'h800, 0, 0, 0, 0,   0, 1, 1, 32'h800, 32'h100, 2,          32'hFFFFFFFF,  0, 1); // 4
    add(0, NOP,          0,     0, 32'h800, 0, 0, 0, 0,   0, 0, 0, 0,       32'h100, 2,          32'hFFFFFFFF,  0, 1); // 5
    add(1, 32'h00000073, 32'h200, 0, 32'h800, 0, 0, 0, 0, 1, 0, 0, 0,       32'h100, 2,          32'hFFFFFFFF,  0, 1); // 6 ecall
    add(0, NOP,          0,     0, 32'h800, 0, 0, 0, 0,   0, 1, 1, 32'h800, 32'h200, 11,         0,             0, 0); // 7
    add(1, 32'h30200073, 32'h500, 0, 32'h800, 0, 0, 0, 0, 1, 0, 0, 0,       32'h200, 11,         0,             0, 0); // 8 mret
    add(0, NOP,          0,     0, 32'h800, 0, 0, 0, 0,   0, 1, 1, 32'h200, 32'h200, 11,         0,             0, 1); // 9
    add(0, NOP,          0,     0, 32'h800, 1, 0, 0, 0,   0, 0, 0, 0,       32'h200, 11,         0,             0, 1); // 10
    add(1, 32'hFFFFFFFF, 32'h300, 1, 32'h800, 0, 0, 1, 0, 1, 0, 0, 0,       32'h200, 11,         0,             1, 1); // 11 tmr>ill
    add(1, NOP,          32'h304, 0, 32'h800, 0, 0, 1, 0, 0, 1, 1, 32'h800, 32'h300, 32'h80000007, 0,           0, 1); // 12 irq waits
    add(1, 32'hDEADBEEF, 32'h304, 1, 32'h800, 0, 0, 1, 0, 1, 0, 0, 0,       32'h300, 32'h80000007, 0,           0, 1); // 13 MIE=0
    add(0, NOP,          0,     0, 32'h800, 0, 0, 0, 0,   0, 1, 1, 32'h800, 32'h304, 2,          32'hDEADBEEF,  0, 0); // 14
    add(0, NOP,          0,     0, 32'h800, 1, 1, 0, 0,   0, 0, 0, 0,       32'h304, 2,          32'hDEADBEEF,  0, 0); // 15 clr wins
    add(0, NOP,          0,     0, 32'h800, 1, 0, 0, 0,   0, 0, 0, 0,       32'h304, 2,          32'hDEADBEEF,  0, 0); // 16
    add(0, NOP,          0,     0, 32'h800, 0, 0, 0, 0,   0, 0, 0, 0,       32'h304, 2,          32'hDEADBEEF,  1, 0); // 17
    for (int i = 0; i < 5; i++)
      add(0, NOP,        32'h400, 0, 32'h800, 0, 0, 1, 0, 0, 0, 0, 0,       32'h304, 2,          32'hDEADBEEF,  1, 0); // 18-22 pending
    add(1, NOP,          32'h400, 0, 32'h800, 0, 0, 1, 0, 1, 0, 0, 0,       32'h304, 2,          32'hDEADBEEF,  1, 0); // 23
    add(0, NOP,          0,     0, 32'h800, 0, 0, 0, 0,   0, 1, 1, 32'h800, 32'h400, 32'h80000007, 0,           0, 1); // 24
    add(0, NOP,          0,     0, 32'h801, 1, 0, 0, 0,   0, 0, 0, 0,       32'h400, 32'h80000007, 0,           0, 1); // 25
    add(1, 32'h00100073, 32'h500, 0, 32'h801, 0, 0, 1, 1, 1, 0, 0, 0,       32'h400, 32'h80000007, 0,           1, 1); // 26 ext>tmr
    add(0, NOP,          0,     0, 32'h801, 0, 0, 0, 0,   0, 1, 1, EXT_RPC, 32'h500, 32'h8000000B, 0,           0, 1); // 27
    add(0, NOP,          0,     0, 32'h801, 0, 0, 0, 0,   0, 0, 0, 0,       32'h500, 32'h8000000B, 0,           0, 1); // 28
    add(1, 32'h00100073, 32'h600, 0, 32'h801, 0, 0, 0, 0, 1, 0, 0, 0,       32'h500, 32'h8000000B, 0,           0, 1); // 29 ebreak
    add(0, NOP,          0,     0, 32'h801, 0, 0, 0, 0,   0, 1, 1, 32'h800, 32'h600, 3,          32'h600,       0, 0); // 30
    add(1, 32'h30200073, 32'h700, 1, 32'h801, 0, 0, 0, 0, 1, 0, 0, 0,       32'h600, 3,          32'h600,       0, 0); // 31 mret+ill
    add(0, NOP,          0,     0, 32'h801, 0, 0, 0, 0,   0, 1, 1, 32'h800, 32'h700, 2,          32'h30200073,  0, 0); // 32
    add(0, NOP,          0,     0, 32'h800, 0, 0, 0, 0,   0, 0, 0, 0,       32'h700, 2,          32'h30200073,  0, 0); // 33

    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      valid_i = vecs[i].v; instr_i = vecs[i].instr; pc_i = vecs[i].pc;
      illegal_i = vecs[i].ill; mtvec_i = vecs[i].mtvec; mie_set_i = vecs[i].set;
      mie_clr_i = vecs[i].clr; timer_irq_i = vecs[i].tmr; ext_irq_i = vecs[i].ext;
      #1;
      chk("kill",   i, {31'h0, kill_o},         {31'h0, vecs[i].kill});
      chk("stall",  i, {31'h0, stall_o},        {31'h0, vecs[i].stall});
      chk("redir",  i, {31'h0, redirect_o},     {31'h0, vecs[i].redir});
      chk("rpc",    i, redirect_pc_o,           vecs[i].rpc);
      chk("mepc",   i, mepc_o,                  vecs[i].mepc);
      chk("mcause", i, mcause_o,                vecs[i].mcause);
      chk("mtval",  i, mtval_o,                 vecs[i].mtval);
      chk("mie",    i, {31'h0, mstatus_mie_o},  {31'h0, vecs[i].mie});
      chk("mpie",   i, {31'h0, mstatus_mpie_o}, {31'h0, vecs[i].mpie});
    end

    // Reset asserted in the middle of a TRAP cycle.
    @(negedge clk);
    drive_idle(); mtvec_i = 32'h800; valid_i = 1; illegal_i = 1; instr_i = 32'h0; pc_i = 32'h900;
    @(negedge clk);
    drive_idle();
    #1;
    chk("rst_pre_redir", 100, {31'h0, redirect_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_redir", 100, {31'h0, redirect_o}, 32'h0);
    chk("rst_stall", 100, {31'h0, stall_o}, 32'h0);
    chk("rst_rpc",   100, redirect_pc_o, 32'h0);
    chk("rst_mepc",  100, mepc_o, 32'h0);
    chk("rst_mcause",100, mcause_o, 32'h0);
    chk("rst_mtval", 100, mtval_o, 32'h0);
    chk("rst_mstat", 100, {30'h0, mstatus_mie_o, mstatus_mpie_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_redir", 101 + c, {31'h0, redirect_o}, 32'h0);
      chk("post_rst_stall", 101 + c, {31'h0, stall_o}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
